sample_pacer: RTL and testbench



---
 rtl/sample_pacer_pkg.sv | 12 +
 rtl/sample_pacer_sync_fifo.sv | 55 +++++
 rtl/sample_pacer.sv | 107 ++++++++++
 tb/tb_sample_pacer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_pacer_pkg.sv
// rtl/sample_pacer_pkg.sv - shared constants and state type for the audio sample pacer
package sample_pacer_pkg;

  localparam int SYNTH_WIDTH        = 24;
  localparam int AUDIO_FRAME_CYCLES = 768;

  typedef enum logic {
    PRIMING = 1'b0,
    RUNNING = 1'b1
  } pacer_state_t;

endpackage

// File: rtl/sample_pacer_sync_fifo.sv
// rtl/sample_pacer_sync_fifo.sv - single-clock FIFO with occupancy count, reusable on the ADC path
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_pacer.sv
// rtl/sample_pacer.sv - buffers bursty samples and releases one held word per audio frame
module sample_pacer
  import sample_pacer_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int PRIME_LEVEL  = 4,
  parameter int FRAME_CYCLES = AUDIO_FRAME_CYCLES
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       valid_in,
  input  logic [SYNTH_WIDTH-1:0]     sample_in,
  output logic                       ready_out,
  output logic [SYNTH_WIDTH-1:0]     sample_out,
  output logic                       valid_out,
  output logic                       frame_tick_out,
  output logic [$clog2(DEPTH):0]     level_out,
  output logic                       underrun_out,
  output logic                       overflow_out
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(FRAME_CYCLES);

  pacer_state_t           state;
  pacer_state_t           state_next;
  logic [CW-1:0]          frame_cnt;
  logic                   tick;
  logic                   push;
  logic                   pop;
  logic                   release_frame;
  logic                   starve;
  logic                   full;
  logic                   empty;
  logic [LW-1:0]          level;
  logic [SYNTH_WIDTH-1:0] head;

  assign tick      = (frame_cnt == CW'(FRAME_CYCLES - 1));
  assign ready_out = !full;
  assign push      = valid_in && ready_out;
  assign level_out = level;

  sync_fifo #(
    .WIDTH (SYNTH_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .push_data (sample_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= PRIMING;
    else        state <= state_next;
  end

  // Pop decisions use the pre-push level, so a word pushed on an empty tick waits a frame.
  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    release_frame = 1'b0;
    starve        = 1'b0;
    if (tick) begin
      case (state)
        PRIMING: begin
          if (level >= LW'(PRIME_LEVEL)) begin
            pop           = 1'b1;
            release_frame = 1'b1;
            state_next    = RUNNING;
          end
        end
        RUNNING: begin
          release_frame = 1'b1;
          if (!empty) pop    = 1'b1;
          else        starve = 1'b1;
        end
        default: state_next = PRIMING;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_cnt      <= '0;
      sample_out     <= '0;
      valid_out      <= 1'b0;
      frame_tick_out <= 1'b0;
      underrun_out   <= 1'b0;
      overflow_out   <= 1'b0;
    end else begin
      frame_cnt      <= tick ? '0 : frame_cnt + CW'(1);
      frame_tick_out <= release_frame;
      if (pop)              sample_out   <= head;
      else if (starve)      sample_out   <= '0;
      if (release_frame)    valid_out    <= 1'b1;
      if (starve)           underrun_out <= 1'b1;
      if (valid_in && full) overflow_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_pacer.sv
// tb/tb_sample_pacer.sv - self-checking bench for sample_pacer
module tb_sample_pacer;
  import sample_pacer_pkg::*;

  localparam int DEPTH = 16;
  localparam int PRIME = 4;
  localparam int FRAME = AUDIO_FRAME_CYCLES;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic                   valid_in;
  logic [SYNTH_WIDTH-1:0] sample_in;
  logic                   ready_out;
  logic [SYNTH_WIDTH-1:0] sample_out;
  logic                   valid_out;
  logic                   frame_tick_out;
  logic [4:0]             level_out;
  logic                   underrun_out;
  logic                   overflow_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: frame counter, FIFO contents as a queue, flags.
  int                     m_cnt;
  bit                     m_run;
  logic [SYNTH_WIDTH-1:0] m_q[$];
  logic [SYNTH_WIDTH-1:0] m_sample;
  bit                     m_valid;
  bit                     m_under;
  bit                     m_over;

  typedef struct {
    logic                   v;
    logic [SYNTH_WIDTH-1:0] d;
    logic                   rdy;
    logic [4:0]             lvl;
    logic                   ovf;
  } vec_t;
  vec_t tbl[20];

  sample_pacer #(
    .DEPTH        (DEPTH),
    .PRIME_LEVEL  (PRIME),
    .FRAME_CYCLES (FRAME)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .sample_in      (sample_in),
    .ready_out      (ready_out),
    .sample_out     (sample_out),
    .valid_out      (valid_out),
    .frame_tick_out (frame_tick_out),
    .level_out      (level_out),
    .underrun_out   (underrun_out),
    .overflow_out   (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_in    = 1'b1;
    valid_in  = 1'b1;
    sample_in = 24'hFFFFFF;
    @(posedge clk_in); #1;
    rst_in    = 1'b0;
    valid_in  = 1'b0;
    sample_in = '0;
    m_cnt = 0; m_run = 0; m_q.delete(); m_sample = '0;
    m_valid = 0; m_under = 0; m_over = 0;
    chk("rst_sample", 32'(sample_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_tick", 32'(frame_tick_out), 32'h0);
    chk("rst_level", 32'(level_out), 32'h0);
    chk("rst_underrun", 32'(underrun_out), 32'h0);
    chk("rst_overflow", 32'(overflow_out), 32'h0);
    chk("rst_ready", 32'(ready_out), 32'h1);
  endtask

  task automatic cycle(input logic v, input logic [SYNTH_WIDTH-1:0] d);
    bit exp_ready;
    bit pulse;
    valid_in  = v;
    sample_in = d;
    exp_ready = (m_q.size() < DEPTH);
    chk("ready", 32'(ready_out), 32'(exp_ready));
    pulse = 0;
    if (m_cnt == FRAME - 1) begin
      if (!m_run) begin
        if (m_q.size() >= PRIME) begin
          m_sample = m_q.pop_front();
          m_run = 1; m_valid = 1; pulse = 1;
        end
      end else begin
        pulse = 1;
        if (m_q.size() > 0) m_sample = m_q.pop_front();
        else begin
          m_sample = '0;
          m_under  = 1;
        end
      end
    end
    if (v) begin
      if (exp_ready) m_q.push_back(d);
      else           m_over = 1;
    end
    m_cnt = (m_cnt == FRAME - 1) ? 0 : m_cnt + 1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    chk("tick", 32'(frame_tick_out), 32'(pulse));
    chk("sample", 32'(sample_out), 32'(m_sample));
    chk("valid", 32'(valid_out), 32'(m_valid));
    chk("level", 32'(level_out), 32'(m_q.size()));
    chk("underrun", 32'(underrun_out), 32'(m_under));
    chk("overflow", 32'(overflow_out), 32'(m_over));
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < 20; i++) begin
      tbl[i].v   = 1'b1;
      tbl[i].d   = 24'(i + 1);
      tbl[i].rdy = (i < 16);
      tbl[i].lvl = (i < 16) ? 5'(i + 1) : 5'd16;
      tbl[i].ovf = (i >= 16);
    end
    rst_in = 1'b1; valid_in = 1'b0; sample_in = '0;
    @(posedge clk_in); #1;
    do_reset();

    // Prime: four pushes at cycles 10..13, first release on the tick at cycle 767.
    for (int t = 0; t < FRAME; t++) begin
      if (t >= 10 && t <= 13) cycle(1'b1, 24'(32'h111 * (t - 9)));
      else                    cycle(1'b0, '0);
    end
    chk("prime_tick", 32'(frame_tick_out), 32'h1);
    chk("prime_sample", 32'(sample_out), 32'h000111);
    chk("prime_valid", 32'(valid_out), 32'h1);
    chk("prime_level", 32'(level_out), 32'd3);
    run_idle(FRAME);
    chk("prime_s2", 32'(sample_out), 32'h000222);
    run_idle(FRAME);
    chk("prime_s3", 32'(sample_out), 32'h000333);
    run_idle(FRAME);
    chk("prime_s4", 32'(sample_out), 32'h000444);

    run_idle(FRAME);
    chk("under_sample", 32'(sample_out), 32'h0);
    chk("under_flag", 32'(underrun_out), 32'h1);
    chk("under_valid", 32'(valid_out), 32'h1);
    chk("under_tick", 32'(frame_tick_out), 32'h1);

    // Mid-operation reset with seven buffered words.
    for (int i = 0; i < 7; i++) cycle(1'b1, 24'(32'h500 + i));
    chk("midrst_level", 32'(level_out), 32'd7);
    do_reset();
    run_idle(FRAME);
    chk("reprime_valid", 32'(valid_out), 32'h0);

    // Sub-prime: three words must not release for three frames.
    for (int i = 0; i < 3; i++) cycle(1'b1, 24'(32'h700 + i));
    run_idle(3 * FRAME - 3);
    chk("subprime_valid", 32'(valid_out), 32'h0);
    chk("subprime_under", 32'(underrun_out), 32'h0);
    chk("subprime_level", 32'(level_out), 32'd3);
    cycle(1'b1, 24'h000703);
    run_idle(FRAME - 1);
    chk("subprime_rel_tick", 32'(frame_tick_out), 32'h1);
    chk("subprime_rel_sample", 32'(sample_out), 32'h000700);

    // Overflow: valid held for 20 cycles from cycle 0.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("tbl_ready", 32'(ready_out), 32'(tbl[i].rdy));
      cycle(tbl[i].v, tbl[i].d);
      chk("tbl_level", 32'(level_out), 32'(tbl[i].lvl));
      chk("tbl_overflow", 32'(overflow_out), 32'(tbl[i].ovf));
    end
    run_idle(FRAME - 20);
    chk("ovf_first", 32'(sample_out), 32'h1);
    run_idle(15 * FRAME);
    chk("ovf_last", 32'(sample_out), 32'd16);
    chk("ovf_no_under", 32'(underrun_out), 32'h0);

    // Tick/empty collision: push on the tick that finds the FIFO empty.
    run_idle(FRAME - 1);
    cycle(1'b1, 24'h00ABCD);
    chk("coll_sample", 32'(sample_out), 32'h0);
    chk("coll_under", 32'(underrun_out), 32'h1);
    chk("coll_level", 32'(level_out), 32'd1);
    run_idle(FRAME);
    chk("coll_next", 32'(sample_out), 32'h00ABCD);
    chk("coll_next_tick", 32'(frame_tick_out), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
